alu_scheduler: RTL and testbench
================================

Name: alu_scheduler

Overview:
Shares one combinational 32-bit integer ALU instance (`alu`) between NUM_REQ requesters, each with a valid/ready request port. A round-robin arbiter picks one request per cycle, drives the ALU, and captures the result in a registered response stage with valid/ready backpressure and a requester ID. It sits between the vector/scalar control units and the shared integer ALU in the accelerator datapath.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, $clog2(NUM_REQ), width of rsp_id (derived; never overridden)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous reset, active-high
req_valid  input  NUM_REQ  per-requester request valid
req_ready  output  NUM_REQ  per-requester accept; at most one bit high per cycle
req_opcode  input  4*NUM_REQ  packed ALU opcodes (`ALU_* encodings); requester i at [4i+3:4i]
req_a  input  32*NUM_REQ  packed operand A; requester i at [32i+31:32i]
req_b  input  32*NUM_REQ  packed operand B; same packing
rsp_valid  output  1  response valid
rsp_ready  input  1  response consumer ready
rsp_id  output  ID_W  index of the requester that owns rsp_data
rsp_data  output  32  ALU result
busy  output  1  high while state != IDLE or rsp_valid

Behaviour:
- Reset (async, while rst=1): rsp_valid=0, rsp_data=0, rsp_id=0, rr_ptr=0, state=IDLE; req_ready forced to 0 combinationally; busy=0.
- Transfer occurs when req_valid[i] & req_ready[i] (request) or rsp_valid & rsp_ready (response).
- can_accept = (state==IDLE) & (!rsp_valid | rsp_ready) & !rst. A response drained this cycle frees the slot for a same-cycle grant (no bubble).
- Arbitration: winner = first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... mod NUM_REQ. req_ready[winner] = can_accept; all other bits 0. req_ready may depend combinationally on req_valid; req_valid must never depend on req_ready.
- On a grant to i: rr_ptr <= (i+1) mod NUM_REQ. rr_ptr does not change without a grant.
- The ALU is driven from the winner's opcode/a/b. On a single-cycle grant: rsp_data <= ALU result, rsp_id <= i, rsp_valid <= 1 at the next edge. Latency is 1 cycle from request handshake to rsp_valid.
- rsp_valid, rsp_data and rsp_id hold stable while rsp_valid & !rsp_ready. rsp_valid clears after a handshake unless a new grant occurs in the same cycle.
- ALU semantics are the shared ALU's, unmodified. Shifts shift B by A[4:0]. SLT is signed and SLTU unsigned, both giving 0/1. MUL keeps the low 32 bits. Undefined opcodes produce 0 and still get a normal response; there is no error signalling.
- FSM states: IDLE and MUL_WAIT. MUL_WAIT exists only with the optional feature enabled; without it the FSM is constant IDLE.
- Simultaneous events: a grant and a response drain in the same cycle are both honoured. A requester that drops req_valid before its grant is not recorded and incurs no penalty.

Optional Feature:
Macro ALU_SCHED_MUL_2CYC_EN.
- Defined:
  - A granted `ALU_MUL latches opcode, A, B and id into an operand register. State goes IDLE->MUL_WAIT, and the ALU is driven from the operand register.
  - In MUL_WAIT, req_ready is all-zero.
  - On the next edge: result is written to rsp_data/rsp_id, rsp_valid<=1, state<=MUL_WAIT->IDLE. MUL latency is 2 cycles.
  - The MUL_WAIT->IDLE edge is taken only if !rsp_valid | rsp_ready. Otherwise the FSM stays in MUL_WAIT.
  - Reset in MUL_WAIT discards the operation; no response is produced.
- Undefined: all opcodes, MUL included, have 1-cycle latency and there is no operand register.

Test Plan:
1. req_valid=0001, `ALU_ADD, a=5, b=7, rsp_ready=1 -> req_ready=0001 same cycle; next cycle rsp_valid=1, rsp_data=12, rsp_id=0.
2. req_valid=1111 held, each requester issuing `ALU_ADD a=i b=100, rsp_ready=1 -> one grant per cycle in order 0,1,2,3,0; rsp_id sequence 0,1,2,3,0 with no bubble cycles.
3. Response pending, rsp_ready=0 for 3 cycles -> req_ready=0000, rsp_data/rsp_id/rsp_valid stable. When rsp_ready rises with req_valid=0100 -> same-cycle grant to 2 and new rsp next cycle.
4. Arithmetic checks:
   - `ALU_SRA a=4, b=0x80000000 -> 0xF8000000
   - `ALU_SLT a=0xFFFFFFFF, b=1 -> 1
   - `ALU_SLTU same operands -> 0
   - `ALU_SUB a=0, b=1 -> 0xFFFFFFFF
   - opcode 4'hF -> 0
5. With ALU_SCHED_MUL_2CYC_EN: `ALU_MUL a=3, b=0x10 from req 1 while req 2 is valid -> busy=1, req_ready=0000 for 1 cycle, rsp_data=0x30 id=1 two cycles after the grant, then req 2 granted. Without the macro: result 1 cycle after the grant.
6. Assert rst during MUL_WAIT (or with rsp_valid=1) -> rsp_valid=0 and req_ready=0000 immediately. After release, no stale response appears and the first grant goes to the lowest valid index (rr_ptr=0).

Source files
------------

// File: rtl/alu_scheduler.sv
// Round-robin scheduler sharing one 32-bit integer ALU between NUM_REQ requesters.
// Define ALU_SCHED_MUL_2CYC_EN to give ALU_MUL a registered operand stage (2-cycle latency).

`ifndef ALU_ADD
`define ALU_ADD  4'h0
`define ALU_SUB  4'h1
`define ALU_AND  4'h2
`define ALU_OR   4'h3
`define ALU_XOR  4'h4
`define ALU_SLL  4'h5
`define ALU_SRL  4'h6
`define ALU_SRA  4'h7
`define ALU_SLT  4'h8
`define ALU_SLTU 4'h9
`define ALU_MUL  4'hA
`endif

module alu (
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  always_comb begin
    case (op)
      `ALU_ADD:  y = a + b;
      `ALU_SUB:  y = a - b;
      `ALU_AND:  y = a & b;
      `ALU_OR:   y = a | b;
      `ALU_XOR:  y = a ^ b;
      `ALU_SLL:  y = b << a[4:0];
      `ALU_SRL:  y = b >> a[4:0];
      `ALU_SRA:  y = $signed(b) >>> a[4:0];
      `ALU_SLT:  y = {31'd0, $signed(a) < $signed(b)};
      `ALU_SLTU: y = {31'd0, a < b};
      `ALU_MUL:  y = a * b;
      default:   y = 32'd0;
    endcase
  end
endmodule

module alu_scheduler #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [4*NUM_REQ-1:0]    req_opcode,
  input  logic [32*NUM_REQ-1:0]   req_a,
  input  logic [32*NUM_REQ-1:0]   req_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [31:0]             rsp_data,
  output logic                    busy
);
  localparam logic [0:0] IDLE = 1'b0;

  logic [0:0]      state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] win;
  logic [ID_W-1:0] win_next;
  logic            found;
  logic            can_accept;
  logic            grant;
  logic [3:0]      win_op;
  logic [31:0]     win_a;
  logic [31:0]     win_b;
  logic [3:0]      alu_op;
  logic [31:0]     alu_a;
  logic [31:0]     alu_b;
  logic [31:0]     alu_y;
  logic            rsp_load;
  logic [ID_W-1:0] rsp_load_id;

  // Walk the ring from the farthest slot back to rr_ptr so the nearest valid requester wins last.
  always_comb begin : arbiter
    int              idx;
    logic [ID_W-1:0] idx_w;
    // NOTE: every combinational output gets a default before any conditional assignment, so no latch is inferred.
    idx   = 0;
    idx_w = '0;
    win   = rr_ptr;
    found = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_w = ID_W'(idx);
      if (req_valid[idx_w]) begin
        found = 1'b1;
        win   = idx_w;
      end
    end
  end

  assign can_accept = (state == IDLE) & (!rsp_valid | rsp_ready) & !rst;
  assign grant      = found & can_accept;
  assign req_ready  = grant ? (NUM_REQ'(1) << win) : '0;
  assign win_next   = (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
  assign win_op     = req_opcode[win*4 +: 4];
  assign win_a      = req_a[win*32 +: 32];
  assign win_b      = req_b[win*32 +: 32];
  assign busy       = (state != IDLE) | rsp_valid;

`ifdef ALU_SCHED_MUL_2CYC_EN
  localparam logic [0:0] MUL_WAIT = 1'b1;

  logic [3:0]      op_q;
  logic [31:0]     a_q;
  logic [31:0]     b_q;
  logic [ID_W-1:0] id_q;
  logic            mul_grant;
  logic            mul_done;

  assign mul_grant   = grant & (win_op == `ALU_MUL);
  assign mul_done    = (state == MUL_WAIT) & (!rsp_valid | rsp_ready);
  assign alu_op      = (state == MUL_WAIT) ? op_q : win_op;
  assign alu_a       = (state == MUL_WAIT) ? a_q  : win_a;
  assign alu_b       = (state == MUL_WAIT) ? b_q  : win_b;
  assign rsp_load    = (grant & !mul_grant) | mul_done;
  assign rsp_load_id = mul_done ? id_q : win;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      id_q  <= '0;
    end else if (mul_grant) begin
      state <= MUL_WAIT;
      op_q  <= win_op;
      a_q   <= win_a;
      b_q   <= win_b;
      id_q  <= win;
    end else if (mul_done) begin
      state <= IDLE;
    end
  end
`else
  assign state       = IDLE;
  assign alu_op      = win_op;
  assign alu_a       = win_a;
  assign alu_b       = win_b;
  assign rsp_load    = grant;
  assign rsp_load_id = win;
`endif

  alu u_alu (
    .op (alu_op),
    .a  (alu_a),
    .b  (alu_b),
    .y  (alu_y)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr    <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
    end else begin
      if (grant) rr_ptr <= win_next;
      if (rsp_load) begin
        rsp_valid <= 1'b1;
        rsp_data  <= alu_y;
        rsp_id    <= rsp_load_id;
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_scheduler.sv
// Scoreboard bench for alu_scheduler: directed requests push expected responses, a monitor checks them.

module tb_alu_scheduler;
  localparam int N = 4;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_SLL  = 4'h5;
  localparam logic [3:0] OP_SRL  = 4'h6;
  localparam logic [3:0] OP_SRA  = 4'h7;
  localparam logic [3:0] OP_SLT  = 4'h8;
  localparam logic [3:0] OP_SLTU = 4'h9;
  localparam logic [3:0] OP_MUL  = 4'hA;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [4*N-1:0]  req_opcode;
  logic [32*N-1:0] req_a;
  logic [32*N-1:0] req_b;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [1:0]      rsp_id;
  logic [31:0]     rsp_data;
  logic            busy;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
  } vec_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  alu_scheduler #(.NUM_REQ(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_opcode (req_opcode),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    req_opcode[4*i +: 4] = op;
    req_a[32*i +: 32]    = a;
    req_b[32*i +: 32]    = b;
  endtask

  task automatic push(input logic [1:0] id, input logic [31:0] data);
    exp_t e;
    e.id   = id;
    e.data = data;
    sb.push_back(e);
  endtask

  // Monitor: every response handshake must match the oldest expected entry.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_rsp", {30'd0, rsp_id}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("rsp_id", {30'd0, rsp_id}, {30'd0, e.id});
          check("rsp_data", rsp_data, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vt[9];
    int   n;

    rst        = 1'b1;
    req_valid  = '1;
    req_opcode = '0;
    req_a      = '0;
    req_b      = '0;
    rsp_ready  = 1'b1;

    // Reset state, with requests pending to show req_ready is held low.
    tick;
    @(negedge clk);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_rsp_id", {30'd0, rsp_id}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_req_ready", {28'd0, req_ready}, 32'd0);
    tick;
    rst       = 1'b0;
    req_valid = '0;

    // 1: single add, 1-cycle latency.
    set_req(0, OP_ADD, 32'd5, 32'd7);
    req_valid = 4'b0001;
    push(2'd0, 32'd12);
    @(negedge clk);
    check("t1_req_ready", {28'd0, req_ready}, 32'h1);
    tick;
    req_valid = '0;
    @(negedge clk);
    check("t1_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("t1_busy", {31'd0, busy}, 32'd1);
    tick;
    @(negedge clk);
    check("t1_drained", {31'd0, rsp_valid}, 32'd0);
    check("t1_idle_busy", {31'd0, busy}, 32'd0);

    // 2: all requesters valid, round-robin from rr_ptr=0 with no bubbles.
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, OP_ADD, 32'(i), 32'd100);
    req_valid = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      push(2'(c % 4), 32'(100 + (c % 4)));
      @(negedge clk);
      check("t2_req_ready", {28'd0, req_ready}, 32'(1 << (c % 4)));
      if (c > 0) check("t2_no_bubble", {31'd0, rsp_valid}, 32'd1);
      tick;
    end
    req_valid = '0;
    @(negedge clk);
    check("t2_last_rsp", {31'd0, rsp_valid}, 32'd1);
    tick;

    // 3: backpressure holds the response and blocks grants; release gives same-cycle grant.
    rsp_ready = 1'b0;
    set_req(1, OP_XOR, 32'h0000_00F0, 32'h0000_00FF);
    req_valid = 4'b0010;
    push(2'd1, 32'h0000_000F);
    @(negedge clk);
    check("t3_grant1", {28'd0, req_ready}, 32'h2);
    tick;
    set_req(2, OP_SUB, 32'd10, 32'd3);
    req_valid = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("t3_stall_ready", {28'd0, req_ready}, 32'h0);
      check("t3_stall_valid", {31'd0, rsp_valid}, 32'd1);
      check("t3_stall_data", rsp_data, 32'h0000_000F);
      check("t3_stall_id", {30'd0, rsp_id}, 32'd1);
      tick;
    end
    rsp_ready = 1'b1;
    push(2'd2, 32'd7);
    @(negedge clk);
    check("t3_same_cycle_grant", {28'd0, req_ready}, 32'h4);
    tick;
    req_valid = '0;
    @(negedge clk);
    check("t3_new_rsp", {31'd0, rsp_valid}, 32'd1);
    tick;

    // 4: ALU corner cases, back to back from requester 3.
    vt[0] = '{OP_SRA,  32'd4,          32'h8000_0000, 32'hF800_0000};
    vt[1] = '{OP_SLT,  32'hFFFF_FFFF,  32'd1,         32'd1};
    vt[2] = '{OP_SLTU, 32'hFFFF_FFFF,  32'd1,         32'd0};
    vt[3] = '{OP_SUB,  32'd0,          32'd1,         32'hFFFF_FFFF};
    vt[4] = '{4'hF,    32'h1234_5678,  32'h9ABC_DEF0, 32'd0};
    vt[5] = '{OP_SLL,  32'd4,          32'd1,         32'h0000_0010};
    vt[6] = '{OP_SRL,  32'd1,          32'h8000_0000, 32'h4000_0000};
    vt[7] = '{OP_AND,  32'hFF00_FF00,  32'h0F0F_0F0F, 32'h0F00_0F00};
    vt[8] = '{OP_OR,   32'hFF00_0000,  32'h0000_00FF, 32'hFF00_00FF};
    n = 9;
    for (int v = 0; v < n; v++) begin
      set_req(3, vt[v].op, vt[v].a, vt[v].b);
      req_valid = 4'b1000;
      push(2'd3, vt[v].res);
      @(negedge clk);
      check("t4_req_ready", {28'd0, req_ready}, 32'h8);
      tick;
    end
    req_valid = '0;
    @(negedge clk);
    tick;

    // 5: MUL from requester 1 while requester 2 waits.
    set_req(1, OP_MUL, 32'd3, 32'h10);
    set_req(2, OP_ADD, 32'd1, 32'd2);
    req_valid = 4'b0110;
    push(2'd1, 32'h30);
    @(negedge clk);
    check("t5_mul_grant", {28'd0, req_ready}, 32'h2);
    tick;
    req_valid = 4'b0100;
`ifdef ALU_SCHED_MUL_2CYC_EN
    @(negedge clk);
    check("t5_wait_ready", {28'd0, req_ready}, 32'h0);
    check("t5_wait_busy", {31'd0, busy}, 32'd1);
    check("t5_wait_valid", {31'd0, rsp_valid}, 32'd0);
    tick;
`endif
    push(2'd2, 32'd3);
    @(negedge clk);
    check("t5_mul_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("t5_mul_rsp_id", {30'd0, rsp_id}, 32'd1);
    check("t5_req2_grant", {28'd0, req_ready}, 32'h4);
    tick;
    req_valid = '0;
    @(negedge clk);
    check("t5_req2_rsp", {31'd0, rsp_valid}, 32'd1);
    tick;

    // 6: reset with an operation in flight; no stale response, rr_ptr back to 0.
    set_req(0, OP_MUL, 32'd6, 32'd7);
    req_valid = 4'b0001;
    @(negedge clk);
    check("t6_grant0", {28'd0, req_ready}, 32'h1);
    tick;
    rst       = 1'b1;
    req_valid = 4'b1111;
    #1;
    check("t6_rst_valid", {31'd0, rsp_valid}, 32'd0);
    check("t6_rst_ready", {28'd0, req_ready}, 32'h0);
    check("t6_rst_busy", {31'd0, busy}, 32'd0);
    tick;
    tick;
    rst = 1'b0;
    set_req(0, OP_ADD, 32'h11, 32'h22);
    set_req(3, OP_ADD, 32'd1, 32'd1);
    req_valid = 4'b1001;
    push(2'd0, 32'h33);
    @(negedge clk);
    check("t6_no_stale", {31'd0, rsp_valid}, 32'd0);
    check("t6_first_grant", {28'd0, req_ready}, 32'h1);
    tick;
    req_valid = '0;
    @(negedge clk);
    check("t6_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    tick;

    // Drain any outstanding expectations within a bounded number of cycles.
    for (int c = 0; c < 20 && sb.size() != 0; c++) tick;
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
